// File: rtl/nf10_oq_fifo_pkg.sv
// Shared helpers for the output-queue FIFOs.
//   depth_of   : capacity in words from log2 depth
//   cnt_width  : width of an occupancy counter able to hold DEPTH itself
//   in_range   : inclusive range check used by elaboration-time parameter guards
//   fifo_flags_t : status flags decoded from the occupancy count
package nf10_oq_fifo_pkg;

  function automatic int depth_of(input int bits);
    return 1 << bits;
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int bits);
    return bits + 1;
  endfunction

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  typedef struct packed {
    logic full;
    logic nearly_full;
    logic empty;
    logic nearly_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fallthrough_small_sync_fifo_if.sv
// Handshake/data bundle for fallthrough_small_sync_fifo.
//   master : producer/consumer side (drives din, wr_en, rd_en; sees data and status)
//   slave  : FIFO side
//   din/dout WIDTH bits, count MAX_DEPTH_BITS+1 bits, remaining signals 1 bit.
interface fallthrough_small_sync_fifo_if #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    nearly_full;
  logic                    empty;
  logic                    nearly_empty;
  logic [MAX_DEPTH_BITS:0] count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, empty, nearly_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, empty, nearly_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fallthrough_fifo_ram.sv
// DEPTH x WIDTH storage for the fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (clears only the read register)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : registered read port; rdata holds mem[raddr] sampled at the
//                    last edge, read-before-write on an address collision
module fallthrough_fifo_ram #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/fallthrough_small_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : slave side of fallthrough_small_sync_fifo_if
//                din/wr_en/rd_en in; dout, full, nearly_full, empty,
//                nearly_empty, count, overflow, underflow out
// Capacity is 2**MAX_DEPTH_BITS words including the word shown on dout.
module fallthrough_small_sync_fifo
  import nf10_oq_fifo_pkg::*;
#(
  parameter int WIDTH             = 72,
  parameter int MAX_DEPTH_BITS    = 3,
  parameter int ALMOST_FULL_SIZE  = 2**MAX_DEPTH_BITS - 1,
  parameter int ALMOST_EMPTY_SIZE = 1
) (
  input logic                          clk,
  input logic                          rst_n,
  fallthrough_small_sync_fifo_if.slave bus
);
  localparam int DEPTH = depth_of(MAX_DEPTH_BITS);
  localparam int CNT_W = cnt_width(MAX_DEPTH_BITS);

  localparam logic [CNT_W-1:0]          CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]          CNT_AF    = CNT_W'(ALMOST_FULL_SIZE);
  localparam logic [CNT_W-1:0]          CNT_AE    = CNT_W'(ALMOST_EMPTY_SIZE);
  localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

  if (!in_range(ALMOST_FULL_SIZE, 1, DEPTH)) begin : g_bad_af
    $error("ALMOST_FULL_SIZE out of range 1..DEPTH");
  end
  if (!in_range(ALMOST_EMPTY_SIZE, 0, DEPTH - 1)) begin : g_bad_ae
    $error("ALMOST_EMPTY_SIZE out of range 0..DEPTH-1");
  end

  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]          count_q;
  logic                      wr_acc, rd_acc;
  logic                      ovf_q, unf_q;
  logic                      byp_sel_q;
  logic [WIDTH-1:0]          byp_q;
  logic [WIDTH-1:0]          ram_rdata;
  fifo_flags_t               flags;

  // Flags come straight from the registered count, so they follow the
  // causing strobe by one edge and drop to reset values with the count.
  always_comb begin
    flags              = '0;
    flags.full         = (count_q == CNT_DEPTH);
    flags.nearly_full  = (count_q >= CNT_AF);
    flags.empty        = (count_q == '0);
    flags.nearly_empty = (count_q <= CNT_AE);
  end

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign wr_acc = bus.wr_en && (!flags.full || bus.rd_en);
  assign rd_acc = bus.rd_en && !flags.empty;

  // The RAM is read at the head pointer as it will be after this edge, so its
  // registered output already holds the new head in the following cycle.
  assign rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      ovf_q <= bus.wr_en && flags.full && !bus.rd_en;
      unf_q <= bus.rd_en && flags.empty;
    end
  end

  // When a word is written to the very slot that becomes the head, the RAM's
  // read-before-write output would be stale for one cycle; serve din instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      byp_sel_q <= wr_acc && (wr_ptr == rd_ptr_nxt);
      if (wr_acc && (wr_ptr == rd_ptr_nxt)) byp_q <= bus.din;
    end
  end

  fallthrough_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (MAX_DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr_nxt),
    .rdata (ram_rdata)
  );

  assign bus.dout         = byp_sel_q ? byp_q : ram_rdata;
  assign bus.full         = flags.full;
  assign bus.nearly_full  = flags.nearly_full;
  assign bus.empty        = flags.empty;
  assign bus.nearly_empty = flags.nearly_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fallthrough_small_sync_fifo.sv
// Bench: two FIFO instances (default thresholds and AE=2/AF=6) share one
// stimulus stream; a queue-based reference model predicts every output.
module tb_fallthrough_small_sync_fifo;
  localparam int W = 72;
  localparam int DB = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;

  always #5 clk = ~clk;

  fallthrough_small_sync_fifo_if #(.WIDTH(W), .MAX_DEPTH_BITS(DB)) ifa ();
  fallthrough_small_sync_fifo_if #(.WIDTH(W), .MAX_DEPTH_BITS(DB)) ifb ();

  assign ifa.din = din;
  assign ifa.wr_en = wr_en;
  assign ifa.rd_en = rd_en;
  assign ifb.din = din;
  assign ifb.wr_en = wr_en;
  assign ifb.rd_en = rd_en;

  fallthrough_small_sync_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(DB)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  fallthrough_small_sync_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(DB),
    .ALMOST_FULL_SIZE(6), .ALMOST_EMPTY_SIZE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // reference model
  logic [W-1:0] mq[$];
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(input string pfx, input logic [DB:0] cnt, input logic e,
                         input logic f, input logic ne, input logic nf, input logic ov,
                         input logic un, input logic [W-1:0] dq, input int ae,
                         input int af, input bit in_rst);
    int sz;
    sz = mq.size();
    chk({pfx, " count"}, W'(cnt), W'(sz));
    chk({pfx, " empty"}, W'(e), W'(sz == 0));
    chk({pfx, " full"}, W'(f), W'(sz == DEPTH));
    chk({pfx, " nearly_empty"}, W'(ne), W'(sz <= ae));
    chk({pfx, " nearly_full"}, W'(nf), W'(sz >= af));
    chk({pfx, " overflow"}, W'(ov), W'(exp_ovf));
    chk({pfx, " underflow"}, W'(un), W'(exp_unf));
    if (in_rst) chk({pfx, " dout_rst"}, dq, '0);
    else if (sz != 0) chk({pfx, " dout"}, dq, mq[0]);
  endtask

  task automatic check_all(input string tag, input bit in_rst);
    chk_one({tag, " A"}, ifa.count, ifa.empty, ifa.full, ifa.nearly_empty,
            ifa.nearly_full, ifa.overflow, ifa.underflow, ifa.dout, 1, 7, in_rst);
    chk_one({tag, " B"}, ifb.count, ifb.empty, ifb.full, ifb.nearly_empty,
            ifb.nearly_full, ifb.overflow, ifb.underflow, ifb.dout, 2, 6, in_rst);
  endtask

  // Apply one cycle of strobes, advance the model by the FIFO rules, compare.
  task automatic step(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    bit was_full, was_empty;
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    #1;
    was_full = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    exp_ovf = w && was_full && !r;
    exp_unf = r && was_empty;
    if (r && !was_empty) void'(mq.pop_front());
    if (w && (!was_full || r)) mq.push_back(d);
    wr_en = 1'b0; rd_en = 1'b0;
    check_all(tag, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    logic [95:0] r96;
    // reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b1);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, '0);

    // single word fall-through, then pop
    step("wr_a1", 1'b1, 1'b0, W'(8'hA1));
    step("rd_a1", 1'b0, 1'b1, '0);

    // fill to full, dropped ninth write, simultaneous write+read while full
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i));
    step("ovf", 1'b1, 1'b0, W'(9));
    step("ovf_clr", 1'b0, 1'b0, '0);
    step("full_wr_rd", 1'b1, 1'b1, W'(8'h10));
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);

    // underflow alone, then underflow with a simultaneous write
    step("unf", 1'b0, 1'b1, '0);
    step("unf_clr", 1'b0, 1'b0, '0);
    step("unf_wr", 1'b1, 1'b1, W'(8'h55));

    // reset mid-stream with five words held, checked before any edge
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, W'(8'h60 + i));
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst", 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b0, '0);

    // seeded random traffic, write-heavy then read-heavy to hit both ends
    void'($urandom(32'd2024));
    for (int i = 0; i < 100; i++) begin
      logic w, r;
      r96 = {$urandom(), $urandom(), $urandom()};
      if (i < 50) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 9) < 7);
      end
      step("rand", w, r, r96[W-1:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
